spi_master: RTL
===============

Name: spi_master

Overview:
SPI-mode-0 initiator for the peripheral shift-register interface. It accepts a parallel word, drives cs_n, sclk and mosi MSB-first, and samples miso on every sclk rising edge. It returns the received word and a one-cycle done pulse. It sits between the FPGA-side control logic and an off-chip or on-chip SPI peripheral such as the shiftregister-based memory.

Parameters:
WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  FPGA clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a transfer; sampled only when ready=1
txData  input  WIDTH  word to send; latched on the accepting edge
ready  output  1  high only in IDLE
busy  output  1  high from the accepting edge until DONE exits
done  output  1  one-cycle pulse; rxData is valid from this cycle on
rxData  output  WIDTH  last received word; held until the next done
sclk  output  1  serial clock; idles low (CPOL=0)
mosi  output  1  serial data out; MSB first
miso  input  1  serial data in
cs_n  output  1  chip select, active low

Behaviour:
- All outputs are registered.
- Reset, and any asynchronous assertion of rst_n (including mid-transfer), forces immediately: state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, ready=1, rxData=0, counters=0.
- States:
  - IDLE: start=1 latches txData into txShift, clears bitCnt/divCnt/rxShift and goes to SETUP.
  - SETUP: cs_n=0, mosi=txShift[MSB], sclk=0. After CLK_DIV cycles go to LEAD; on that transition sclk<=1 and rxShift<={rxShift[WIDTH-2:0],miso}.
  - LEAD: sclk=1 for CLK_DIV cycles. At its end sclk<=0. If bitCnt==WIDTH-1, go to HOLD. Otherwise txShift shifts left by one, bitCnt++, mosi<=new MSB, and go to TRAIL.
  - TRAIL: sclk=0 for CLK_DIV cycles, then go to LEAD. On that transition sclk<=1 and miso is sampled.
  - HOLD: cs_n=0, sclk=0 for CLK_DIV cycles, then go to DONE.
  - DONE: one cycle with cs_n=1, done=1, rxData<=rxShift, busy still 1, then go to IDLE.
- mosi changes only on falling sclk transitions or in SETUP, so it is stable for CLK_DIV cycles before each rising edge.
- miso is sampled in the same clk edge that raises sclk.
- Exactly WIDTH rising sclk edges occur per transfer.
- Latency: done is high after edge N=(2*WIDTH+1)*CLK_DIV counted from the accepting edge (edge 0). With WIDTH=8, CLK_DIV=2, N=34.
- start while busy (including during DONE) is ignored; there is no queueing. A new transfer can be accepted on the first IDLE cycle after DONE, so cs_n is high for at least 2 cycles between transfers.
- txData changes after the accepting edge have no effect.
- divCnt wraps 0..CLK_DIV-1. bitCnt is $clog2(WIDTH) bits and never wraps within a transfer.
- mosi returns to 0 in IDLE.

Decomposition:
- spi_pkg holds the state enum (IDLE, SETUP, LEAD, TRAIL, HOLD, DONE) and the CPOL/CPHA mode constants (fixed at 0/0).
- One sub-module, spi_shifter, holds the WIDTH-bit tx/rx shift pair with load, shiftOut and sampleIn strobes.
- The FSM and divider stay in spi_master.

Test Plan:
1. Reset: hold rst_n=0 with start=1 -> cs_n=1, sclk=0, mosi=0, busy=0, done=0, ready=1, rxData=0x00; no sclk edges.
2. Loopback (miso=mosi), txData=0xA5, CLK_DIV=2 -> mosi at the 8 rising edges is 1,0,1,0,0,1,0,1; done pulses at edge 34 for 1 cycle; rxData=0xA5; cs_n rises at edge 34.
3. miso tied 1, txData=0x00 -> mosi 0 throughout, exactly 8 sclk rising edges, rxData=0xFF; then miso=0, txData=0xFF -> rxData=0x00.
4. start held high continuously for 3 transfers of 0x3C -> exactly 3 done pulses 36 edges apart; start pulses during busy produce no extra transfer or sclk edge.
5. rst_n pulsed low just after the 3rd sclk rising edge -> cs_n=1, sclk=0, busy=0 with no clock edge needed, rxData=0x00. A following transfer of 0x5A in loopback returns 0x5A.
6. CLK_DIV=1, WIDTH=8, loopback 0xC3 -> sclk period 2 clk, done at edge 17, rxData=0xC3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI mode-0 initiator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL,
        HOLD,
        DONE
    } spi_state_e;

    // Mode is fixed: sclk idles low, data captured on the leading (rising) edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_shifter.sv
// Transmit/receive shift register pair: parallel load, MSB-first shift out, LSB-side shift in.
module spi_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_out,
    input  logic             sample_in,
    input  logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_next_msb,
    output logic [WIDTH-1:0] rx_shift
);

    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;

    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load) begin
            tx_d = tx_data;
            rx_d = '0;
        end else begin
            if (shift_out) tx_d = {tx_q[WIDTH-2:0], 1'b0};
            if (sample_in) rx_d = {rx_q[WIDTH-2:0], miso};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

    // Bit that becomes the MSB after the next shift; drives mosi on the falling sclk.
    assign tx_next_msb = tx_q[WIDTH-2];
    assign rx_shift    = rx_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: FSM and sclk divider around a tx/rx shifter, all outputs registered.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rxData,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;

    logic             load, shift_out, sample_in, div_end, tx_next_msb;
    logic [WIDTH-1:0] rx_shift;

    spi_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .shift_out  (shift_out),
        .sample_in  (sample_in),
        .miso       (miso),
        .tx_data    (txData),
        .tx_next_msb(tx_next_msb),
        .rx_shift   (rx_shift)
    );

    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ready_d   = ready_q;
        rx_data_d = rx_data_q;
        load      = 1'b0;
        shift_out = 1'b0;
        sample_in = 1'b0;

        if (state_q inside {SETUP, LEAD, TRAIL, HOLD})
            div_d = div_end ? '0 : div_q + 1'b1;

        case (state_q)
            IDLE: begin
                mosi_d = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    state_d = SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = txData[WIDTH-1];
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            SETUP, TRAIL: begin
                // miso is captured on the same edge that raises sclk
                if (div_end) begin
                    state_d   = LEAD;
                    sclk_d    = 1'b1;
                    sample_in = 1'b1;
                end
            end
            LEAD: begin
                if (div_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
                        state_d = HOLD;
                    end else begin
                        shift_out = 1'b1;
                        bit_d     = bit_q + 1'b1;
                        mosi_d    = tx_next_msb;
                        state_d   = TRAIL;
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    state_d   = DONE;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift;
                end
            end
            DONE: begin
                state_d = IDLE;
                div_d   = '0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                mosi_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign rxData = rx_data_q;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;
    assign cs_n   = cs_n_q;

endmodule
